player_motion_ctrl: RTL and testbench

- Downstream consumer of the accelerometer direction stage. Takes the four tilt-direction levels (right_x, left_x, up_y, down_y) and converts them into a rate-limited, bounds-clamped player position for the maze game.
- Before committing each step, performs a wall-collision lookup through a req/ack handshake with the maze map block.
- The resulting position drives the renderer and the win/lose logic.

---
 rtl/player_motion_ctrl.sv | 153 +++++++++++++++
 tb/tb_player_motion_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// Converts tilt-direction levels into a rate-limited, clamped player position,
// checking every step against the maze map through a req/ack wall lookup.
module player_motion_ctrl #(
  parameter int STEP_PERIOD = 5000000,
  parameter int STEP        = 4,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_right_x,
  input  logic       i_left_x,
  input  logic       i_up_y,
  input  logic       i_down_y,
  input  logic       i_restart,
  input  logic       i_wall_ack,
  input  logic       i_wall_hit,
  output logic       o_wall_req,
  output logic [9:0] o_wall_x,
  output logic [9:0] o_wall_y,
  output logic [9:0] o_pos_x,
  output logic [9:0] o_pos_y,
  output logic       o_moved,
  output logic       o_blocked
);

  // state  | meaning
  // IDLE   | waiting for a movement tick with a non-trivial target
  // REQ    | wall lookup outstanding, timeout counter running
  // DONE   | one quiet cycle for the map before the next request

  localparam int TW = $clog2(STEP_PERIOD);
  localparam int OW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_PERIOD - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(ACK_TIMEOUT - 1);
  localparam logic [10:0]   STEP11    = 11'(STEP);
  localparam logic [10:0]   XMAX11    = 11'(X_MAX);
  localparam logic [10:0]   YMAX11    = 11'(Y_MAX);
  localparam logic [9:0]    XINIT10   = 10'(X_INIT);
  localparam logic [9:0]    YINIT10   = 10'(Y_INIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic [OW-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic [9:0]      r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
  logic [9:0]      r_wall_x, r_wall_y, w_wall_x_nxt, w_wall_y_nxt;
  logic            r_moved, r_blocked, w_moved_nxt, w_blocked_nxt;
  logic [10:0]     w_px, w_py, w_x_up, w_y_up, w_tx, w_ty;
  logic            w_target_moves;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || w_tick) r_tick_cnt <= '0;
    else                   r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // 11-bit arithmetic so pos+STEP cannot wrap before the clamp
  always_comb begin
    w_px   = {1'b0, r_pos_x};
    w_py   = {1'b0, r_pos_y};
    w_x_up = w_px + STEP11;
    w_y_up = w_py + STEP11;
    w_tx   = w_px;
    w_ty   = w_py;
    if (i_right_x && !i_left_x)      w_tx = (w_x_up > XMAX11) ? XMAX11 : w_x_up;
    else if (i_left_x && !i_right_x) w_tx = (w_px < STEP11) ? 11'd0 : w_px - STEP11;
    if (i_down_y && !i_up_y)         w_ty = (w_y_up > YMAX11) ? YMAX11 : w_y_up;
    else if (i_up_y && !i_down_y)    w_ty = (w_py < STEP11) ? 11'd0 : w_py - STEP11;
    w_target_moves = (w_tx != w_px) || (w_ty != w_py);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = r_to_cnt;
    w_pos_x_nxt   = r_pos_x;
    w_pos_y_nxt   = r_pos_y;
    w_wall_x_nxt  = r_wall_x;
    w_wall_y_nxt  = r_wall_y;
    w_moved_nxt   = 1'b0;
    w_blocked_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_to_cnt_nxt = '0;
        if (w_tick && w_target_moves) begin
          w_wall_x_nxt = w_tx[9:0];
          w_wall_y_nxt = w_ty[9:0];
          w_state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        // an ack in the final timeout cycle still counts
        if (i_wall_ack) begin
          if (i_wall_hit) begin
            w_blocked_nxt = 1'b1;
          end else begin
            w_pos_x_nxt = r_wall_x;
            w_pos_y_nxt = r_wall_y;
            w_moved_nxt = 1'b1;
          end
          w_state_nxt = S_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_blocked_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + OW'(1);
        end
      end
      S_DONE: begin
        w_to_cnt_nxt = '0;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_restart) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_pos_x   <= XINIT10;
      r_pos_y   <= YINIT10;
      r_wall_x  <= '0;
      r_wall_y  <= '0;
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_pos_x   <= w_pos_x_nxt;
      r_pos_y   <= w_pos_y_nxt;
      r_wall_x  <= w_wall_x_nxt;
      r_wall_y  <= w_wall_y_nxt;
      r_moved   <= w_moved_nxt;
      r_blocked <= w_blocked_nxt;
    end
  end

  assign o_wall_req = (r_state == S_REQ);
  assign o_wall_x   = r_wall_x;
  assign o_wall_y   = r_wall_y;
  assign o_pos_x    = r_pos_x;
  assign o_pos_y    = r_pos_y;
  assign o_moved    = r_moved;
  assign o_blocked  = r_blocked;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Randomized bench for player_motion_ctrl with a position/tick-phase model
// and a bench-driven map responder.
module tb_player_motion_ctrl;
  localparam int P    = 8;
  localparam int STEP = 4;
  localparam int XMAX = 639;
  localparam int YMAX = 479;
  localparam int XI   = 320;
  localparam int YI   = 240;
  localparam int TO   = 15;

  logic clk = 1'b0;
  logic reset, restart, right_x, left_x, up_y, down_y, wall_ack, wall_hit;
  logic wall_req, moved, blocked;
  logic [9:0] wall_x, wall_y, pos_x, pos_y;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_x, exp_y;
  int ecnt;

  player_motion_ctrl #(.STEP_PERIOD(P), .STEP(STEP)) dut (
    .i_clk(clk), .i_reset(reset), .i_right_x(right_x), .i_left_x(left_x),
    .i_up_y(up_y), .i_down_y(down_y), .i_restart(restart),
    .i_wall_ack(wall_ack), .i_wall_hit(wall_hit), .o_wall_req(wall_req),
    .o_wall_x(wall_x), .o_wall_y(wall_y), .o_pos_x(pos_x), .o_pos_y(pos_y),
    .o_moved(moved), .o_blocked(blocked)
  );

  always #5 clk = ~clk;

  // edges since the last reset; a request may only begin when this is a multiple of P
  always @(posedge clk) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dirs(input bit r, input bit l, input bit u, input bit d);
    right_x = r; left_x = l; up_y = u; down_y = d;
  endtask

  function automatic int next_coord(input int p, input bit inc, input bit dec, input int maxv);
    if (inc && !dec) return (p + STEP > maxv) ? maxv : p + STEP;
    if (dec && !inc) return (p < STEP) ? 0 : p - STEP;
    return p;
  endfunction

  task automatic do_move(input string nm, input bit r, input bit l, input bit u, input bit d,
                         input bit hit, input int dly, input bit no_ack);
    int tx, ty, bad;
    bit seen;
    tx = next_coord(exp_x, r, l, XMAX);
    ty = next_coord(exp_y, d, u, YMAX);
    set_dirs(r, l, u, d);
    if (tx == exp_x && ty == exp_y) begin
      bad = 0;
      for (int i = 0; i < 2 * P + 2; i++) begin
        step();
        if (wall_req || moved || blocked) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL %s_no_req: %0d cycles with req/pulse, expected 0", nm, bad);
      end
      n_tests++;
      if (pos_x !== 10'(exp_x) || pos_y !== 10'(exp_y)) begin
        n_fail++;
        $display("FAIL %s_hold_pos: got (%0d,%0d) expected (%0d,%0d)", nm, pos_x, pos_y, exp_x, exp_y);
      end
      set_dirs(0, 0, 0, 0);
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * P + 2 && !seen; i++) begin
      step();
      seen = wall_req;
    end
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_req: wall_req never rose, expected within %0d cycles", nm, 2 * P + 2);
      set_dirs(0, 0, 0, 0);
      return;
    end
    n_tests++;
    if (ecnt % P !== 0) begin
      n_fail++;
      $display("FAIL %s_phase: req began at edge %0d, expected a multiple of %0d", nm, ecnt, P);
    end
    n_tests++;
    if (wall_x !== 10'(tx) || wall_y !== 10'(ty)) begin
      n_fail++;
      $display("FAIL %s_target: got (%0d,%0d) expected (%0d,%0d)", nm, wall_x, wall_y, tx, ty);
    end
    {right_x, left_x, up_y, down_y} = 4'($urandom);
    bad = 0;
    for (int i = 0; i < (no_ack ? TO - 1 : dly); i++) begin
      step();
      if (wall_req !== 1'b1 || wall_x !== 10'(tx) || wall_y !== 10'(ty)) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s_req_hold: %0d bad cycles while waiting, expected 0", nm, bad);
    end
    if (!no_ack) begin
      wall_ack = 1'b1;
      wall_hit = hit;
    end
    step();
    wall_ack = 1'b0;
    wall_hit = 1'($urandom);
    if (!no_ack && !hit) begin
      exp_x = tx;
      exp_y = ty;
    end
    n_tests++;
    if (wall_req !== 1'b0 || moved !== (!no_ack && !hit) || blocked !== (no_ack || hit)) begin
      n_fail++;
      $display("FAIL %s_result: req=%b moved=%b blocked=%b expected req=0 moved=%b blocked=%b",
               nm, wall_req, moved, blocked, !no_ack && !hit, no_ack || hit);
    end
    n_tests++;
    if (pos_x !== 10'(exp_x) || pos_y !== 10'(exp_y)) begin
      n_fail++;
      $display("FAIL %s_pos: got (%0d,%0d) expected (%0d,%0d)", nm, pos_x, pos_y, exp_x, exp_y);
    end
    step();
    n_tests++;
    if (wall_req !== 1'b0 || moved !== 1'b0 || blocked !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_quiet: req=%b moved=%b blocked=%b expected all 0", nm, wall_req, moved, blocked);
    end
    set_dirs(0, 0, 0, 0);
  endtask

  task automatic wait_req(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * P + 2 && !seen; i++) begin
      step();
      seen = wall_req;
    end
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_req: wall_req never rose, expected within %0d cycles", nm, 2 * P + 2);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; restart = 1'b0; wall_ack = 1'b0; wall_hit = 1'b0;
    set_dirs(0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    exp_x = XI; exp_y = YI;
    n_tests++;
    if (pos_x !== 10'd320 || pos_y !== 10'd240) begin
      n_fail++;
      $display("FAIL reset_pos: got (%0d,%0d) expected (320,240)", pos_x, pos_y);
    end
    n_tests++;
    if (wall_req !== 1'b0 || wall_x !== 10'd0 || wall_y !== 10'd0 || moved !== 1'b0 || blocked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: req=%b wall=(%0d,%0d) moved=%b blocked=%b expected all 0",
               wall_req, wall_x, wall_y, moved, blocked);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (wall_req || moved || blocked) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_move_right();
    for (int i = 0; i < 3; i++) do_move("right", 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_diag_blocked();
    for (int i = 0; i < 3; i++) do_move("diag_hit", 0, 1, 0, 1, 1, 0, 0);
  endtask

  task automatic test_timeout();
    do_move("timeout", 1, 0, 0, 0, 0, 0, 1);
    do_move("ack_wins", 1, 0, 0, 0, 0, TO - 1, 0);
  endtask

  task automatic test_restart();
    set_dirs(1, 0, 0, 0);
    wait_req("restart");
    set_dirs(0, 0, 0, 0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    exp_x = XI; exp_y = YI;
    n_tests++;
    if (wall_req !== 1'b0 || pos_x !== 10'd320 || pos_y !== 10'd240) begin
      n_fail++;
      $display("FAIL restart_state: req=%b pos=(%0d,%0d) expected req=0 pos=(320,240)", wall_req, pos_x, pos_y);
    end
    wall_ack = 1'b1; wall_hit = 1'b0;
    step();
    wall_ack = 1'b0;
    n_tests++;
    if (moved !== 1'b0 || blocked !== 1'b0 || pos_x !== 10'd320 || pos_y !== 10'd240) begin
      n_fail++;
      $display("FAIL restart_late_ack: moved=%b blocked=%b pos=(%0d,%0d) expected 0,0,(320,240)",
               moved, blocked, pos_x, pos_y);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      do_move("random", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), int'($urandom_range(0, 4)), $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic test_clamp();
    restart = 1'b1;
    step();
    restart = 1'b0;
    exp_x = XI; exp_y = YI;
    for (int i = 0; i < 100 && exp_x < XMAX; i++) do_move("clamp_right", 1, 0, 0, 0, 0, 0, 0);
    do_move("at_x_max", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100 && exp_y > 0; i++) do_move("clamp_up", 0, 0, 1, 0, 0, 0, 0);
    do_move("at_y_min", 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_reset_restart();
    set_dirs(0, 0, 0, 1);
    wait_req("rst_rs");
    set_dirs(0, 0, 0, 0);
    reset = 1'b1; restart = 1'b1;
    step();
    reset = 1'b0; restart = 1'b0;
    exp_x = XI; exp_y = YI;
    n_tests++;
    if (wall_req !== 1'b0 || pos_x !== 10'd320 || pos_y !== 10'd240 || wall_x !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_rs_state: req=%b pos=(%0d,%0d) wall_x=%0d expected 0,(320,240),0",
               wall_req, pos_x, pos_y, wall_x);
    end
    do_move("after_rst_rs", 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_diag_blocked();
    test_timeout();
    test_restart();
    test_random();
    test_clamp();
    test_reset_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
